// File: rtl/offset_add_arbiter_pkg.sv
// rtl/offset_add_arbiter_pkg.sv - shared constants and types for the offset-add arbiter
//
// Purpose: requester ID encodings, default per-requester offsets and the
//          result-slot state type used by the offset-add arbiter and its
//          round-robin sub-arbiter.
// Ports:   none (package).
package offset_add_arbiter_pkg;

    localparam logic ID_A = 1'b0;
    localparam logic ID_B = 1'b1;

    localparam int DEF_OFFSET_A = 2;
    localparam int DEF_OFFSET_B = 5;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

endpackage

// File: rtl/offset_add_arbiter_rr_arbiter_2.sv
// rtl/offset_add_arbiter_rr_arbiter_2.sv - two-way round-robin arbiter
//
// Purpose: grants one of two requesters; when both request, the one named by
//          the priority pointer wins. The pointer moves to the other
//          requester only when an enabled grant (an actual accept) happens.
// Ports:
//   clk       clock
//   reset     asynchronous active-low reset (pointer returns to A)
//   req_a_i   requester A request
//   req_b_i   requester B request
//   en_i      grant is consumed this cycle when high
//   grant_o   one-hot grant {B, A}; may be high while en_i is low
module rr_arbiter_2
    import offset_add_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       req_a_i,
    input  logic       req_b_i,
    input  logic       en_i,
    output logic [1:0] grant_o
);

    logic prio_q;
    logic prio_d;

    always_comb begin
        grant_o = 2'b00;
        if (req_a_i && req_b_i) begin
            grant_o = (prio_q == ID_A) ? 2'b01 : 2'b10;
        end else if (req_a_i) begin
            grant_o = 2'b01;
        end else if (req_b_i) begin
            grant_o = 2'b10;
        end
    end

    // Priority goes to whichever requester was not just served.
    always_comb begin
        prio_d = prio_q;
        if (en_i && grant_o[0]) begin
            prio_d = ID_B;
        end else if (en_i && grant_o[1]) begin
            prio_d = ID_A;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prio_q <= ID_A;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/offset_add_arbiter.sv
// rtl/offset_add_arbiter.sv - two-requester shared offset adder with one result slot
//
// Purpose: arbitrates requesters A and B onto one registered adder stage,
//          adds a per-requester offset and returns the tagged result through
//          a single valid/ready response port. Keeps saturating accept counts.
// Ports:
//   clk, reset               clock, asynchronous active-low reset
//   a_valid_i/a_ready_o/a_data_i   requester A handshake and operand
//   b_valid_i/b_ready_o/b_data_i   requester B handshake and operand
//   resp_valid_o/resp_ready_i      result handshake
//   resp_data_o              operand + offset (wraps)
//   resp_id_o                0 = A, 1 = B
//   cnt_a_o/cnt_b_o          saturating accept counters
module offset_add_arbiter
    import offset_add_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int OFFSET_A   = DEF_OFFSET_A,
    parameter int OFFSET_B   = DEF_OFFSET_B,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  a_valid_i,
    output logic                  a_ready_o,
    input  logic [DATA_WIDTH-1:0] a_data_i,
    input  logic                  b_valid_i,
    output logic                  b_ready_o,
    input  logic [DATA_WIDTH-1:0] b_data_i,
    output logic                  resp_valid_o,
    input  logic                  resp_ready_i,
    output logic [DATA_WIDTH-1:0] resp_data_o,
    output logic                  resp_id_o,
    output logic [CNT_WIDTH-1:0]  cnt_a_o,
    output logic [CNT_WIDTH-1:0]  cnt_b_o
);

    slot_state_e           state_q;
    slot_state_e           state_d;
    logic                  can_accept;
    logic [1:0]            grant;
    logic                  accept_a;
    logic                  accept_b;
    logic [DATA_WIDTH-1:0] resp_data_q;
    logic [DATA_WIDTH-1:0] resp_data_d;
    logic                  resp_id_q;
    logic                  resp_id_d;
    logic [CNT_WIDTH-1:0]  cnt_a_q;
    logic [CNT_WIDTH-1:0]  cnt_a_d;
    logic [CNT_WIDTH-1:0]  cnt_b_q;
    logic [CNT_WIDTH-1:0]  cnt_b_d;

    // A full slot can take a new result in the same cycle it is drained.
    assign can_accept = (state_q == SLOT_EMPTY) || resp_ready_i;

    rr_arbiter_2 u_arb (
        .clk     (clk),
        .reset   (reset),
        .req_a_i (a_valid_i),
        .req_b_i (b_valid_i),
        .en_i    (can_accept),
        .grant_o (grant)
    );

    assign a_ready_o = can_accept && grant[0];
    assign b_ready_o = can_accept && grant[1];
    assign accept_a  = a_ready_o && a_valid_i;
    assign accept_b  = b_ready_o && b_valid_i;

    // Slot FSM: state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= SLOT_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Slot FSM: next state.
    always_comb begin
        state_d = state_q;
        if (accept_a || accept_b) begin
            state_d = SLOT_FULL;
        end else if ((state_q == SLOT_FULL) && resp_ready_i) begin
            state_d = SLOT_EMPTY;
        end
    end

    // Slot FSM: outputs.
    always_comb begin
        resp_valid_o = (state_q == SLOT_FULL);
    end

    always_comb begin
        resp_data_d = resp_data_q;
        resp_id_d   = resp_id_q;
        if (accept_a) begin
            resp_data_d = a_data_i + DATA_WIDTH'(OFFSET_A);
            resp_id_d   = ID_A;
        end else if (accept_b) begin
            resp_data_d = b_data_i + DATA_WIDTH'(OFFSET_B);
            resp_id_d   = ID_B;
        end
    end

    always_comb begin
        cnt_a_d = cnt_a_q;
        cnt_b_d = cnt_b_q;
        if (accept_a && (cnt_a_q != '1)) begin
            cnt_a_d = cnt_a_q + 1'b1;
        end
        if (accept_b && (cnt_b_q != '1)) begin
            cnt_b_d = cnt_b_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            resp_data_q <= '0;
            resp_id_q   <= ID_A;
            cnt_a_q     <= '0;
            cnt_b_q     <= '0;
        end else begin
            resp_data_q <= resp_data_d;
            resp_id_q   <= resp_id_d;
            cnt_a_q     <= cnt_a_d;
            cnt_b_q     <= cnt_b_d;
        end
    end

    assign resp_data_o = resp_data_q;
    assign resp_id_o   = resp_id_q;
    assign cnt_a_o     = cnt_a_q;
    assign cnt_b_o     = cnt_b_q;

endmodule

// File: doc/offset_add_arbiter.md
Name: offset_add_arbiter

Overview:
- Shares one registered offset-adder stage between two requesters, A and B, through valid/ready handshakes.
- Adds a per-requester offset (A: +2, B: +5) to each accepted operand and returns the result tagged with the requester ID through a single response port.
- Round-robin arbitration when both requesters are valid.
- Per-requester saturating accept counters for debug visibility.
- Sits between the free-running counter and downstream consumers in the basic hierarchy test designs.

Parameters:
- DATA_WIDTH, 32, operand/result width.
- OFFSET_A, 2, constant added to requester A operands.
- OFFSET_B, 5, constant added to requester B operands.
- CNT_WIDTH, 16, width of per-requester accept counters.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset.
- a_valid  input  1  requester A has an operand.
- a_ready  output  1  A operand accepted this cycle when a_valid and a_ready are both high.
- a_data  input  DATA_WIDTH  requester A operand.
- b_valid  input  1  requester B has an operand.
- b_ready  output  1  B operand accepted this cycle when b_valid and b_ready are both high.
- b_data  input  DATA_WIDTH  requester B operand.
- resp_valid  output  1  result register holds a result.
- resp_ready  input  1  consumer accepts the result.
- resp_data  output  DATA_WIDTH  operand + offset.
- resp_id  output  1  0 = A, 1 = B.
- cnt_a  output  CNT_WIDTH  number of A accepts, saturating.
- cnt_b  output  CNT_WIDTH  number of B accepts, saturating.

Behaviour:
- Reset (reset low, asynchronous):
  - resp_valid=0, resp_data=0, resp_id=0.
  - Priority pointer = A.
  - cnt_a=0, cnt_b=0.
  - Any held result is discarded. No accept occurs while reset is low.
- Slot state: one result register, states EMPTY and FULL.
  - can_accept = EMPTY | (FULL & resp_ready).
- Grant (combinational):
  - Only one valid requester: it is granted if can_accept.
  - Both valid: the requester named by the priority pointer is granted.
  - a_ready = can_accept & grant_a; b_ready = can_accept & grant_b.
  - a_ready and b_ready are never both high.
  - Ready may depend on valid; valid must not depend on ready.
- Priority pointer:
  - Updates only on an accept.
  - Points to the requester that was not just granted: accept of A → B has priority next; accept of B → A.
  - Unchanged on idle cycles and stalled cycles.
- Datapath:
  - On accept at edge N: resp_data = operand + offset, truncated to DATA_WIDTH (wraps modulo 2^DATA_WIDTH, no carry out).
  - resp_id is set at the same edge; resp_valid=1 after edge N.
  - Latency is 1 cycle.
- Output handshake:
  - resp_valid & resp_ready with no new accept → EMPTY at the next edge.
  - resp_valid & resp_ready with a simultaneous accept → stays FULL with the new result. Back-to-back throughput is 1 per cycle.
  - resp_valid & !resp_ready → resp_data and resp_id hold stable; no accepts.
- Counters:
  - cnt_a / cnt_b increment on each A / B accept.
  - Saturate at all-ones; no wrap.
- Requester rule: once valid is high it stays high with stable data until accepted. The block does not check this rule.

Decomposition:
- Shared include file holds:
  - Requester ID constants: ID_A=1'b0, ID_B=1'b1.
  - Default offset values.
- Sub-module rr_arbiter_2: two requests plus an enable (= can_accept) in; one-hot grant out; owns the priority pointer and updates it on enabled grants.
- Datapath, result register and counters stay in the top module.

Test Plan:
- Single A request: a_data=10, resp_ready=1 → a_ready=1 the same cycle; next cycle resp_valid=1, resp_data=12, resp_id=0; cnt_a=1.
- Both valid continuously with resp_ready=1, a_data=100, b_data=200, out of reset → grant order A,B,A,B; outputs 102(id0), 205(id1), 102, 205 on consecutive cycles.
- Backpressure: fill the slot with B data 7, then hold resp_ready=0 for 3 cycles with a_valid=1 → resp_data=12 and id=1 stable; a_ready=0 throughout. Raising resp_ready → A accepted the same cycle; the next result is A operand + 2.
- Wrap: a_data=32'hFFFF_FFFF → resp_data=1; b_data=32'hFFFF_FFFC → resp_data=1.
- Counter saturation with CNT_WIDTH=2: 5 A accepts → cnt_a=3 and stays 3; cnt_b=0.
- Async reset mid-operation: slot FULL, pointer at B. Assert reset between edges → resp_valid drops immediately, counters read 0. After release with both valid → A is granted first.
